lsu_mem_stage: RTL and testbench
================================

# lsu_mem_stage

Memory stage of the RV32 pipeline, directly downstream of the execute-stage ALU. It takes each retiring EX instruction. Non-memory results pass to writeback after one register stage. Loads and stores use the ALU result as a byte address and run a request/grant/response transaction on the data-memory port. The block performs byte-lane steering, sign/zero extension of loads, and stalls EX while a transaction is outstanding.

## Interface
Parameters:
- `RESP_TIMEOUT`, default 0 (0 = no timeout). Reserved and unused; must stay 0.

Ports:
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `ex_valid` in 1: EX presents an instruction.
- `ex_ready` out 1: stage accepts; transfer occurs when `ex_valid & ex_ready`.
- `ex_result` in 32: ALU result, which is also the memory byte address.
- `ex_store_data` in 32: rs2 value for stores.
- `ex_mem_op` in 2 (`MEM_OP`): `MEM_NONE`, `MEM_LOAD`, `MEM_STORE`.
- `ex_mem_size` in 2 (`MEM_SIZE`): `MEM_B`, `MEM_H`, `MEM_W`.
- `ex_unsigned` in 1: zero-extend the load (LBU/LHU).
- `ex_rd` in 5: destination register.
- `mem_req` out 1, `mem_gnt` in 1: request/grant.
- `mem_we` out 1, `mem_addr` out 32 (word-aligned, [1:0]=0), `mem_be` out 4, `mem_wdata` out 32.
- `mem_rvalid` in 1, `mem_rdata` in 32: load response.
- `wb_valid` out 1, `wb_we` out 1, `wb_rd` out 5, `wb_data` out 32: writeback. There is no back-pressure.
- `trap_valid` out 1, `trap_cause` out 4, `trap_addr` out 32: misalignment trap.

## Operation
- FSM states (`lsu_state_t`): `IDLE`, `REQ`, `WAIT_RESP`.
- `ex_ready = (state == IDLE)`.
- In `IDLE`, on transfer:
  - `MEM_NONE`: register `wb_data = ex_result` and `wb_rd`, `wb_we = (rd != 0)`, and pulse `wb_valid` next cycle. Stay `IDLE`.
  - `MEM_LOAD`/`MEM_STORE`, aligned: latch address, size, unsigned flag, rd and steered store data. Go to `REQ`.
- `REQ`:
  - `mem_req = 1` with stable `mem_addr/we/be/wdata` until `mem_gnt`.
  - On gnt, a store goes to `IDLE` and pulses `wb_valid` with `wb_we = 0`.
  - On gnt, a load goes to `WAIT_RESP`.
- `WAIT_RESP`: on `mem_rvalid`, register the extracted data to `wb_data`, pulse `wb_valid` with `wb_we = (rd != 0)`, and go to `IDLE`.
- Store steering: byte gives `wdata = {4{b}}`, `be = 4'b0001 << a[1:0]`. Half gives `{2{h}}`, `be = 4'b0011 << {a[1],1'b0}`. Word gives `be = 4'hF`.
- Load extraction: byte from lane `a[1:0]`, half from `a[1]`, then sign- or zero-extend per `ex_unsigned`. Word passes through.
- `mem_rvalid` outside `WAIT_RESP` is ignored.
- `mem_gnt` outside `REQ` is ignored.
- Reset, including mid-transaction: state `IDLE`. All outputs 0 except `ex_ready = 1`. A late response after reset is discarded.

## Timing
- Non-memory op: accepted in cycle N, `wb_valid` in N+1. Throughput is 1 per cycle.
- Store: accepted in N, `mem_req` from N+1 through the gnt cycle G, `wb_valid` at G+1. `ex_ready` goes high at G+1.
- Load: `mem_rvalid` at R ≥ G+1, `wb_valid` at R+1. Minimum load latency is 3 cycles.
- `wb_valid` is a single-cycle pulse per instruction. A new instruction may be accepted in the same cycle as `wb_valid`.
- All outputs are registered except `ex_ready`, which is decoded from state.

## Configuration
- `RV32_LSU_MISALIGN_TRAP_EN`, when defined:
  - A misaligned access (half with `a[0]`, word with `a[1:0] != 0`) issues no memory request.
  - `trap_valid` pulses in N+1 with `trap_cause` 4 (load) or 6 (store) and `trap_addr = ex_result`.
  - No `wb_valid`; state stays `IDLE`.
- Undefined:
  - No check. Misaligned addresses are forced down to natural alignment (half ignores `a[0]`, word ignores `a[1:0]`).
  - `trap_*` are tied to 0.

## Structure
- `rv32_pipeline_pkg` holds:
  - the `MEM_OP`, `MEM_SIZE` and `lsu_state_t` enums;
  - the constants `CAUSE_LOAD_MISALIGN = 4` and `CAUSE_STORE_MISALIGN = 6`.
- One combinational sub-module, `lsu_align`, computes the store `be`/`wdata` and the load extract/extend from address, size and unsigned flag.
- The FSM and registers live in `lsu_mem_stage`.

## Test plan
- Non-memory op: `ex_result = 0x1234`, rd=5 → next cycle `wb_valid = 1`, `wb_data = 0x1234`, `wb_we = 1`. Back-to-back ops complete one per cycle.
- Store byte: `addr = 0x1003`, data = 0xAB, gnt delayed 3 cycles → `mem_addr = 0x1000`, `be = 4'b1000`, `wdata = 0xABABABAB`, all held stable; `wb_valid` with `wb_we = 0` one cycle after gnt.
- Load half signed: `addr = 0x2002`, rdata = 0x8001_0000 → `wb_data = 0xFFFF8001`. The LHU variant gives 0x00008001.
- Load byte: rd=0, rvalid two cycles after gnt → `wb_valid = 1`, `wb_we = 0`. `ex_ready` is low throughout the transaction.
- Misaligned LW at 0x3001: with the macro, `trap_valid`, cause 4, `trap_addr = 0x3001`, no `mem_req`. Without the macro, `mem_addr = 0x3000` and `be = 4'hF`.
- Assert `rst_n` low while in `WAIT_RESP`, then release; a stray `mem_rvalid` follows → no `wb_valid`, state `IDLE`, `ex_ready = 1`.

Source files
------------

// File: rtl/rv32_pipeline_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | rv32_pipeline_pkg: shared memory-op encodings, LSU states, trap causes |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package rv32_pipeline_pkg;

  typedef enum logic [1:0] {
    MEM_NONE  = 2'd0,
    MEM_LOAD  = 2'd1,
    MEM_STORE = 2'd2
  } mem_op_t;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2
  } mem_size_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REQ       = 2'd1,
    WAIT_RESP = 2'd2
  } lsu_state_t;

  localparam logic [3:0] CAUSE_LOAD_MISALIGN  = 4'd4;
  localparam logic [3:0] CAUSE_STORE_MISALIGN = 4'd6;

  function automatic logic is_misaligned(input logic [1:0] addr_lo, input logic [1:0] size);
    logic mis;
    mis = 1'b0;
    case (size)
      MEM_B:   mis = 1'b0;
      MEM_H:   mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_align: store byte-lane steering and load extract/sign-extend     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lsu_align
  import rv32_pipeline_pkg::*;
(
  input  logic [1:0]  st_addr,
  input  logic [1:0]  st_size,
  input  logic [31:0] st_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  input  logic [1:0]  ld_addr,
  input  logic [1:0]  ld_size,
  input  logic        ld_unsigned,
  input  logic [31:0] rdata,
  output logic [31:0] ld_data
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  // Half lane uses only a[1], so a misaligned half is forced to natural alignment.
  always_comb begin
    be    = 4'hF;
    wdata = st_data;
    case (st_size)
      MEM_B: begin
        be    = 4'b0001 << st_addr;
        wdata = {4{st_data[7:0]}};
      end
      MEM_H: begin
        be    = 4'b0011 << {st_addr[1], 1'b0};
        wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    byte_v  = rdata[{ld_addr, 3'b000} +: 8];
    half_v  = ld_addr[1] ? rdata[31:16] : rdata[15:0];
    ld_data = rdata;
    case (ld_size)
      MEM_B:   ld_data = {{24{~ld_unsigned & byte_v[7]}}, byte_v};
      MEM_H:   ld_data = {{16{~ld_unsigned & half_v[15]}}, half_v};
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | lsu_mem_stage: RV32 memory stage (req/gnt/rvalid data port, stalls EX)|
// | Optional misalignment trap: define RV32_LSU_MISALIGN_TRAP_EN          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module lsu_mem_stage
  import rv32_pipeline_pkg::*;
#(
  parameter int RESP_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  output logic        ex_ready,
  input  logic [31:0] ex_result,
  input  logic [31:0] ex_store_data,
  input  logic [1:0]  ex_mem_op,
  input  logic [1:0]  ex_mem_size,
  input  logic        ex_unsigned,
  input  logic [4:0]  ex_rd,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        wb_valid,
  output logic        wb_we,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        trap_valid,
  output logic [3:0]  trap_cause,
  output logic [31:0] trap_addr
);

  // Timeout is reserved; refuse to elaborate with anything but 0.
  if (RESP_TIMEOUT != 0) begin : g_timeout_reserved
    $error("lsu_mem_stage: RESP_TIMEOUT is reserved and must be 0");
  end

  lsu_state_t  state;
  logic [4:0]  lat_rd;
  logic [1:0]  lat_addr_lo;
  logic [1:0]  lat_size;
  logic        lat_unsigned;
  logic [3:0]  st_be;
  logic [31:0] st_wdata;
  logic [31:0] ld_data;
  logic        accept;
  logic        is_mem;
  logic        trap_now;

  assign ex_ready = (state == IDLE);
  assign accept   = ex_valid & ex_ready;
  assign is_mem   = (ex_mem_op == MEM_LOAD) || (ex_mem_op == MEM_STORE);

  lsu_align u_align (
    .st_addr     (ex_result[1:0]),
    .st_size     (ex_mem_size),
    .st_data     (ex_store_data),
    .be          (st_be),
    .wdata       (st_wdata),
    .ld_addr     (lat_addr_lo),
    .ld_size     (lat_size),
    .ld_unsigned (lat_unsigned),
    .rdata       (mem_rdata),
    .ld_data     (ld_data)
  );

`ifdef RV32_LSU_MISALIGN_TRAP_EN
  assign trap_now = is_mem & is_misaligned(ex_result[1:0], ex_mem_size);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trap_valid <= 1'b0;
      trap_cause <= 4'd0;
      trap_addr  <= 32'd0;
    end else begin
      trap_valid <= accept & trap_now;
      if (accept & trap_now) begin
        trap_cause <= (ex_mem_op == MEM_STORE) ? CAUSE_STORE_MISALIGN : CAUSE_LOAD_MISALIGN;
        trap_addr  <= ex_result;
      end
    end
  end
`else
  assign trap_now   = 1'b0;
  assign trap_valid = 1'b0;
  assign trap_cause = 4'd0;
  assign trap_addr  = 32'd0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= 32'd0;
      mem_be       <= 4'd0;
      mem_wdata    <= 32'd0;
      wb_valid     <= 1'b0;
      wb_we        <= 1'b0;
      wb_rd        <= 5'd0;
      wb_data      <= 32'd0;
      lat_rd       <= 5'd0;
      lat_addr_lo  <= 2'd0;
      lat_size     <= 2'd0;
      lat_unsigned <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept && !is_mem) begin
            wb_valid <= 1'b1;
            wb_we    <= (ex_rd != 5'd0);
            wb_rd    <= ex_rd;
            wb_data  <= ex_result;
          end else if (accept && !trap_now) begin
            state        <= REQ;
            mem_req      <= 1'b1;
            mem_we       <= (ex_mem_op == MEM_STORE);
            mem_addr     <= {ex_result[31:2], 2'b00};
            mem_be       <= st_be;
            mem_wdata    <= st_wdata;
            lat_rd       <= ex_rd;
            lat_addr_lo  <= ex_result[1:0];
            lat_size     <= ex_mem_size;
            lat_unsigned <= ex_unsigned;
          end
        end
        REQ: begin
          if (mem_gnt) begin
            mem_req <= 1'b0;
            if (mem_we) begin
              state    <= IDLE;
              wb_valid <= 1'b1;
              wb_we    <= 1'b0;
              wb_rd    <= lat_rd;
            end else begin
              state <= WAIT_RESP;
            end
          end
        end
        WAIT_RESP: begin
          if (mem_rvalid) begin
            state    <= IDLE;
            wb_valid <= 1'b1;
            wb_we    <= (lat_rd != 5'd0);
            wb_rd    <= lat_rd;
            wb_data  <= ld_data;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_lsu_mem_stage: directed self-checking bench for lsu_mem_stage     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_lsu_mem_stage;
  import rv32_pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic [31:0] ex_result = 32'd0;
  logic [31:0] ex_store_data = 32'd0;
  logic [1:0]  ex_mem_op = 2'd0;
  logic [1:0]  ex_mem_size = 2'd0;
  logic        ex_unsigned = 1'b0;
  logic [4:0]  ex_rd = 5'd0;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'd0;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        trap_valid;
  logic [3:0]  trap_cause;
  logic [31:0] trap_addr;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  lsu_mem_stage #(.RESP_TIMEOUT(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_result(ex_result),
    .ex_store_data(ex_store_data), .ex_mem_op(ex_mem_op), .ex_mem_size(ex_mem_size),
    .ex_unsigned(ex_unsigned), .ex_rd(ex_rd),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data),
    .trap_valid(trap_valid), .trap_cause(trap_cause), .trap_addr(trap_addr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] sdata, input logic [4:0] rd);
    ex_valid = 1'b1; ex_mem_op = op; ex_mem_size = size; ex_unsigned = uns;
    ex_result = addr; ex_store_data = sdata; ex_rd = rd;
    tick();
    ex_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    vectors++; if (ex_ready !== 1'b1) begin miscompares++; $display("FAIL reset_ex_ready: got %b want 1", ex_ready); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
    vectors++; if (wb_data !== 32'd0) begin miscompares++; $display("FAIL reset_wb_data: got %h want 0", wb_data); end
    vectors++; if (trap_valid !== 1'b0) begin miscompares++; $display("FAIL reset_trap_valid: got %b want 0", trap_valid); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_non_mem();
    ex_valid = 1'b1; ex_mem_op = MEM_NONE; ex_result = 32'h1234; ex_rd = 5'd5;
    tick();
    vectors++; if (wb_valid !== 1'b1) begin miscompares++; $display("FAIL nonmem_valid: got %b want 1", wb_valid); end
    vectors++; if (wb_data !== 32'h1234) begin miscompares++; $display("FAIL nonmem_data: got %h want 00001234", wb_data); end
    vectors++; if (wb_we !== 1'b1) begin miscompares++; $display("FAIL nonmem_we: got %b want 1", wb_we); end
    vectors++; if (wb_rd !== 5'd5) begin miscompares++; $display("FAIL nonmem_rd: got %0d want 5", wb_rd); end
    // second op back to back, rd=0
    ex_result = 32'h55; ex_rd = 5'd0;
    tick();
    ex_valid = 1'b0;
    vectors++; if (wb_valid !== 1'b1) begin miscompares++; $display("FAIL b2b_valid: got %b want 1", wb_valid); end
    vectors++; if (wb_data !== 32'h55) begin miscompares++; $display("FAIL b2b_data: got %h want 00000055", wb_data); end
    vectors++; if (wb_we !== 1'b0) begin miscompares++; $display("FAIL b2b_we: got %b want 0", wb_we); end
    tick();
    vectors++; if (wb_valid !== 1'b0) begin miscompares++; $display("FAIL nonmem_pulse: got %b want 0", wb_valid); end
  endtask

  task automatic test_store_byte();
    issue(MEM_STORE, MEM_B, 1'b0, 32'h1003, 32'h0000_00AB, 5'd7);
    for (int i = 0; i < 3; i++) begin
      vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL sb_req[%0d]: got %b want 1", i, mem_req); end
      vectors++; if (mem_addr !== 32'h1000) begin miscompares++; $display("FAIL sb_addr[%0d]: got %h want 00001000", i, mem_addr); end
      vectors++; if (mem_be !== 4'b1000) begin miscompares++; $display("FAIL sb_be[%0d]: got %b want 1000", i, mem_be); end
      vectors++; if (mem_wdata !== 32'hABABABAB) begin miscompares++; $display("FAIL sb_wdata[%0d]: got %h want abababab", i, mem_wdata); end
      vectors++; if (mem_we !== 1'b1) begin miscompares++; $display("FAIL sb_we[%0d]: got %b want 1", i, mem_we); end
      vectors++; if (ex_ready !== 1'b0) begin miscompares++; $display("FAIL sb_ready[%0d]: got %b want 0", i, ex_ready); end
      if (i == 2) mem_gnt = 1'b1;
      tick();
    end
    mem_gnt = 1'b0;
    vectors++; if (wb_valid !== 1'b1) begin miscompares++; $display("FAIL sb_wb_valid: got %b want 1", wb_valid); end
    vectors++; if (wb_we !== 1'b0) begin miscompares++; $display("FAIL sb_wb_we: got %b want 0", wb_we); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL sb_req_drop: got %b want 0", mem_req); end
    vectors++; if (ex_ready !== 1'b1) begin miscompares++; $display("FAIL sb_ready_back: got %b want 1", ex_ready); end
  endtask

  task automatic test_store_half_word();
    issue(MEM_STORE, MEM_H, 1'b0, 32'h5002, 32'h1234_5678, 5'd1);
    vectors++; if (mem_be !== 4'b1100) begin miscompares++; $display("FAIL sh_be: got %b want 1100", mem_be); end
    vectors++; if (mem_wdata !== 32'h56785678) begin miscompares++; $display("FAIL sh_wdata: got %h want 56785678", mem_wdata); end
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    issue(MEM_STORE, MEM_W, 1'b0, 32'h5004, 32'hCAFE_F00D, 5'd1);
    vectors++; if (mem_be !== 4'hF) begin miscompares++; $display("FAIL sw_be: got %h want f", mem_be); end
    vectors++; if (mem_wdata !== 32'hCAFEF00D) begin miscompares++; $display("FAIL sw_wdata: got %h want cafef00d", mem_wdata); end
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
  endtask

  task automatic test_load_half(input logic uns, input logic [31:0] expd);
    issue(MEM_LOAD, MEM_H, uns, 32'h2002, 32'd0, 5'd9);
    vectors++; if (mem_we !== 1'b0 || mem_addr !== 32'h2000) begin miscompares++; $display("FAIL lh_req: got we=%b addr=%h want we=0 addr=00002000", mem_we, mem_addr); end
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    vectors++; if (mem_req !== 1'b0 || ex_ready !== 1'b0) begin miscompares++; $display("FAIL lh_wait: got req=%b ready=%b want 0/0", mem_req, ex_ready); end
    mem_rvalid = 1'b1; mem_rdata = 32'h8001_0000; tick(); mem_rvalid = 1'b0;
    vectors++; if (wb_valid !== 1'b1 || wb_we !== 1'b1 || wb_rd !== 5'd9) begin miscompares++; $display("FAIL lh_wb: got valid=%b we=%b rd=%0d want 1/1/9", wb_valid, wb_we, wb_rd); end
    vectors++; if (wb_data !== expd) begin miscompares++; $display("FAIL lh_data(uns=%b): got %h want %h", uns, wb_data, expd); end
  endtask

  task automatic test_load_byte_rd0();
    // stray rvalid/gnt while idle must have no effect
    mem_rvalid = 1'b1; mem_gnt = 1'b1; tick(); mem_rvalid = 1'b0; mem_gnt = 1'b0;
    vectors++; if (wb_valid !== 1'b0 || mem_req !== 1'b0) begin miscompares++; $display("FAIL idle_stray: got wb_valid=%b req=%b want 0/0", wb_valid, mem_req); end
    issue(MEM_LOAD, MEM_B, 1'b0, 32'h4001, 32'd0, 5'd0);
    vectors++; if (ex_ready !== 1'b0) begin miscompares++; $display("FAIL lb_ready_req: got %b want 0", ex_ready); end
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    tick();
    vectors++; if (ex_ready !== 1'b0 || wb_valid !== 1'b0) begin miscompares++; $display("FAIL lb_wait: got ready=%b wb_valid=%b want 0/0", ex_ready, wb_valid); end
    mem_rvalid = 1'b1; mem_rdata = 32'h0000_8000; tick(); mem_rvalid = 1'b0;
    vectors++; if (wb_valid !== 1'b1 || wb_we !== 1'b0) begin miscompares++; $display("FAIL lb_wb: got valid=%b we=%b want 1/0", wb_valid, wb_we); end
    vectors++; if (wb_data !== 32'hFFFFFF80) begin miscompares++; $display("FAIL lb_data: got %h want ffffff80", wb_data); end
  endtask

  task automatic test_misaligned();
    issue(MEM_LOAD, MEM_W, 1'b0, 32'h3001, 32'd0, 5'd3);
`ifdef RV32_LSU_MISALIGN_TRAP_EN
    vectors++; if (trap_valid !== 1'b1 || trap_cause !== 4'd4) begin miscompares++; $display("FAIL mis_trap: got valid=%b cause=%0d want 1/4", trap_valid, trap_cause); end
    vectors++; if (trap_addr !== 32'h3001) begin miscompares++; $display("FAIL mis_trap_addr: got %h want 00003001", trap_addr); end
    vectors++; if (mem_req !== 1'b0 || wb_valid !== 1'b0 || ex_ready !== 1'b1) begin miscompares++; $display("FAIL mis_noreq: got req=%b wb=%b ready=%b want 0/0/1", mem_req, wb_valid, ex_ready); end
    tick();
    vectors++; if (trap_valid !== 1'b0) begin miscompares++; $display("FAIL mis_pulse: got %b want 0", trap_valid); end
`else
    vectors++; if (mem_req !== 1'b1 || mem_addr !== 32'h3000 || mem_be !== 4'hF) begin miscompares++; $display("FAIL mis_align: got req=%b addr=%h be=%h want 1/00003000/f", mem_req, mem_addr, mem_be); end
    vectors++; if (trap_valid !== 1'b0) begin miscompares++; $display("FAIL mis_notrap: got %b want 0", trap_valid); end
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF; tick(); mem_rvalid = 1'b0;
    vectors++; if (wb_valid !== 1'b1 || wb_data !== 32'hDEADBEEF) begin miscompares++; $display("FAIL mis_lw_data: got valid=%b data=%h want 1/deadbeef", wb_valid, wb_data); end
`endif
  endtask

  task automatic test_reset_mid();
    issue(MEM_LOAD, MEM_W, 1'b0, 32'h6000, 32'd0, 5'd4);
    mem_gnt = 1'b1; tick(); mem_gnt = 1'b0;
    vectors++; if (ex_ready !== 1'b0) begin miscompares++; $display("FAIL rmid_in_wait: got ready=%b want 0", ex_ready); end
    rst_n = 1'b0;
    #1;
    vectors++; if (ex_ready !== 1'b1 || mem_req !== 1'b0 || wb_valid !== 1'b0) begin miscompares++; $display("FAIL rmid_async: got ready=%b req=%b wb=%b want 1/0/0", ex_ready, mem_req, wb_valid); end
    tick();
    rst_n = 1'b1;
    mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222; tick(); mem_rvalid = 1'b0;
    vectors++; if (wb_valid !== 1'b0 || ex_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_late_resp: got wb=%b ready=%b want 0/1", wb_valid, ex_ready); end
    tick();
    vectors++; if (wb_valid !== 1'b0 || wb_data !== 32'd0) begin miscompares++; $display("FAIL rmid_after: got wb=%b data=%h want 0/0", wb_valid, wb_data); end
  endtask

  initial begin
    test_reset();
    test_non_mem();
    test_store_byte();
    test_store_half_word();
    test_load_half(1'b0, 32'hFFFF8001);
    test_load_half(1'b1, 32'h00008001);
    test_load_byte_rd0();
    test_misaligned();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
